// File: rtl/xswitch_egress_port.sv
// Egress port of the crossbar switch: captures words from the switch with a
// three-state handshake, drops misrouted words and buffers the rest in a FIFO.
module xswitch_egress_port #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned PORT_ID = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        sw_data,
  input  logic [ADDR_W-1:0]        sw_addr,
  input  logic                     sw_data_rdy,
  output logic                     sw_data_read,
  output logic                     rcv_rdy,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               misroute_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0]   DepthCnt = CntW'(DEPTH);
  localparam logic [ADDR_W-1:0] OwnAddr  = ADDR_W'(PORT_ID);

  typedef enum logic [1:0] {StIdle, StAck, StWait} state_e;

  state_e            state_q;
  logic              read_q;
  logic [7:0]        misroute_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic full, capture, push, pop;

  always_comb begin
    full    = (count_q == DepthCnt);
    capture = (state_q == StIdle) && sw_data_rdy && !full;
    push    = capture && (sw_addr == OwnAddr);
    pop     = (count_q != '0) && out_ready;
  end

  // Capture handshake; sw_data_read is a registered one-cycle pulse in StAck.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      read_q     <= 1'b0;
      misroute_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          read_q <= 1'b0;
          if (capture) begin
            state_q <= StAck;
            read_q  <= 1'b1;
            if (!push && misroute_q != 8'hFF) begin
              misroute_q <= misroute_q + 8'd1;
            end
          end
        end
        StAck: begin
          state_q <= StWait;
          read_q  <= 1'b0;
        end
        StWait: begin
          read_q <= 1'b0;
          // Hold here until the switch drops the word so it is never taken twice.
          if (!sw_data_rdy) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          read_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; out_data is masked while the FIFO is empty instead.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= sw_data;
    end
  end

  always_comb begin
    out_valid    = (count_q != '0);
    out_data     = out_valid ? mem[rd_ptr_q] : '0;
    rcv_rdy      = (count_q < DepthCnt);
    fifo_count   = count_q;
    misroute_cnt = misroute_q;
    sw_data_read = read_q;
  end

endmodule

// File: tb/tb_xswitch_egress_port.sv
// Randomised and directed checks of xswitch_egress_port against a
// queue-based reference model of the handshake and FIFO.
module tb_xswitch_egress_port;

  localparam int DEPTH   = 8;
  localparam int PORT_ID = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw_data;
  logic [1:0] sw_addr;
  logic       sw_data_rdy;
  logic       sw_data_read;
  logic       rcv_rdy;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] fifo_count;
  logic [7:0] misroute_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int   q[$];
  int   mis;
  bit   m_ack, m_wait;
  logic exp_read;
  int   dut_sink[$];
  int   max_cnt;
  int   acks;
  bit   got;

  xswitch_egress_port #(
    .DATA_W (8),
    .ADDR_W (2),
    .DEPTH  (DEPTH),
    .PORT_ID(PORT_ID)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_data     (sw_data),
    .sw_addr     (sw_addr),
    .sw_data_rdy (sw_data_rdy),
    .sw_data_read(sw_data_read),
    .rcv_rdy     (rcv_rdy),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fifo_count  (fifo_count),
    .misroute_cnt(misroute_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mis      = 0;
    m_ack    = 1'b0;
    m_wait   = 1'b0;
    exp_read = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit cap;
    int sz;
    cap      = 1'b0;
    sz       = q.size();
    exp_read = 1'b0;
    if (m_ack) begin
      m_ack  = 1'b0;
      m_wait = 1'b1;
    end else if (m_wait) begin
      if (!sw_data_rdy) m_wait = 1'b0;
    end else if (sw_data_rdy && sz < DEPTH) begin
      cap      = 1'b1;
      m_ack    = 1'b1;
      exp_read = 1'b1;
    end
    if (sz > 0 && out_ready) void'(q.pop_front());
    if (cap) begin
      if (int'(sw_addr) == PORT_ID) q.push_back(int'(sw_data));
      else if (mis < 255) mis++;
    end
  endtask

  task automatic check_all();
    check("sw_data_read", sw_data_read, exp_read);
    check("fifo_count", fifo_count, q.size());
    check("out_valid", out_valid, q.size() != 0);
    check("out_data", out_data, (q.size() != 0) ? q[0] : 0);
    check("rcv_rdy", rcv_rdy, q.size() < DEPTH);
    check("misroute_cnt", misroute_cnt, mis);
  endtask

  task automatic step();
    if (out_valid && out_ready) dut_sink.push_back(int'(out_data));
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
  endtask

  // Switch-side driver: hold the word until acknowledged, then drop rdy.
  task automatic send(input logic [7:0] d, input logic [1:0] a);
    sw_data     = d;
    sw_addr     = a;
    sw_data_rdy = 1'b1;
    got         = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      step();
      got = sw_data_read;
    end
    check("send_ack", got, 1'b1);
    sw_data_rdy = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    sw_data     = '0;
    sw_addr     = '0;
    sw_data_rdy = 1'b0;
    out_ready   = 1'b0;
    max_cnt     = 0;
    model_reset();
    #2;
    check("rst_read", sw_data_read, 0);
    check("rst_count", fifo_count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_rcv_rdy", rcv_rdy, 1);
    check("rst_out_data", out_data, 0);
    check("rst_misroute", misroute_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Single word held for three cycles
    sw_data = 8'hA5; sw_addr = 2'd0; sw_data_rdy = 1'b1;
    acks = 0;
    repeat (3) begin
      step();
      acks += int'(sw_data_read);
    end
    sw_data_rdy = 1'b0;
    step();
    check("single_acks", acks, 1);
    check("single_count", fifo_count, 1);
    check("single_data", out_data, 8'hA5);
    check("single_valid", out_valid, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Misrouted words and saturation
    send(8'h3C, 2'd2);
    check("mis_count", fifo_count, 0);
    check("mis_one", misroute_cnt, 1);
    for (int i = 0; i < 299; i++) send(8'(i), 2'(1 + i % 3));
    check("mis_sat", misroute_cnt, 255);

    // Full FIFO backpressure
    dut_sink.delete();
    for (int i = 1; i <= 8; i++) send(8'(i), 2'd0);
    check("full_count", fifo_count, 8);
    check("full_rcv_rdy", rcv_rdy, 0);
    sw_data = 8'h09; sw_addr = 2'd0; sw_data_rdy = 1'b1;
    acks = 0;
    repeat (4) begin
      step();
      acks += int'(sw_data_read);
    end
    check("full_noack", acks, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = sw_data_read;
    end
    check("full_late_ack", got, 1);
    sw_data_rdy = 1'b0;
    repeat (2) step();
    out_ready = 1'b1;
    repeat (12) step();
    out_ready = 1'b0;
    check("full_sink_len", dut_sink.size(), 9);
    for (int i = 0; i < 9 && i < dut_sink.size(); i++) check("full_sink_order", dut_sink[i], i + 1);

    // Concurrent push/pop with wrap
    dut_sink.delete();
    max_cnt   = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) send(8'h40 + 8'(i), 2'd0);
    repeat (3) step();
    check("conc_max_le1", max_cnt <= 1, 1);
    check("conc_sink_len", dut_sink.size(), 12);
    for (int i = 0; i < 12 && i < dut_sink.size(); i++) check("conc_order", dut_sink[i], 8'h40 + i);
    out_ready = 1'b0;

    // Reset in the ACK state
    sw_data = 8'h77; sw_addr = 2'd0; sw_data_rdy = 1'b1;
    step();
    check("mid_read_hi", sw_data_read, 1);
    reset = 1'b0;
    #1;
    model_reset();
    check("mid_read_lo", sw_data_read, 0);
    check("mid_count", fifo_count, 0);
    check("mid_valid", out_valid, 0);
    check("mid_rcv_rdy", rcv_rdy, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    check("post_rst_capture", sw_data_read, 1);
    sw_data_rdy = 1'b0;
    repeat (2) step();

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      sw_data_rdy = ($urandom_range(0, 9) < 6);
      sw_data     = 8'($urandom);
      sw_addr     = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
      out_ready   = 1'($urandom_range(0, 1));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
